// File: rtl/rggen_rtl_pkg.sv
// Shared register-protocol types: access status codes and access direction.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic {
        RGGEN_READ  = 1'b0,
        RGGEN_WRITE = 1'b1
    } rggen_direction;

endpackage

// File: rtl/rggen_host_bridge_response_mux.sv
// Combinational merge of the per-register responses into one status/data pair.
module rggen_response_mux
    import rggen_rtl_pkg::*;
#(
    parameter int REGISTERS  = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic [REGISTERS-1:0]            select,
    input  logic [REGISTERS-1:0]            ready,
    input  logic [2*REGISTERS-1:0]          status,
    input  logic [DATA_WIDTH*REGISTERS-1:0] read_data,
    output logic                            hit,
    output logic                            any_select,
    output rggen_status                     hit_status,
    output logic [DATA_WIDTH-1:0]           hit_read_data
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves a latch behind.
        hit           = 1'b0;
        any_select    = 1'b0;
        hit_status    = RGGEN_OKAY;
        hit_read_data = '0;
        // Walk from the top index down so the lowest-index hit writes the status last.
        for (int i = REGISTERS - 1; i >= 0; i--) begin
            any_select = any_select | select[i];
            if (select[i] && ready[i]) begin
                hit           = 1'b1;
                hit_read_data = hit_read_data | read_data[DATA_WIDTH*i +: DATA_WIDTH];
                hit_status    = rggen_status'(status[2*i +: 2]);
            end
        end
    end

endmodule

// File: rtl/rggen_host_bridge.sv
// Register bus initiator: one host command in, one register request out, one response back.
module rggen_host_bridge
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTERS      = 1,
    parameter int TIMEOUT_CYCLES = 0,
    parameter bit ERROR_STATUS   = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_host_valid,
    output logic                            o_host_ready,
    input  logic [ADDRESS_WIDTH-1:0]        i_host_address,
    input  logic                            i_host_write,
    input  logic [DATA_WIDTH-1:0]           i_host_write_data,
    input  logic [DATA_WIDTH/8-1:0]         i_host_write_strobe,
    output logic                            o_host_response_valid,
    input  logic                            i_host_response_ready,
    output rggen_status                     o_host_status,
    output logic [DATA_WIDTH-1:0]           o_host_read_data,
    output logic                            o_register_request,
    output logic [ADDRESS_WIDTH-1:0]        o_register_address,
    output rggen_direction                  o_register_direction,
    output logic [DATA_WIDTH-1:0]           o_register_write_data,
    output logic [DATA_WIDTH/8-1:0]         o_register_write_strobe,
    input  logic [REGISTERS-1:0]            i_register_select,
    input  logic [REGISTERS-1:0]            i_register_ready,
    input  logic [2*REGISTERS-1:0]          i_register_status,
    input  logic [DATA_WIDTH*REGISTERS-1:0] i_register_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPONSE} state_e;

    localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e                  state;
    state_e                  next_state;
    logic [COUNT_WIDTH-1:0]  count;
    logic                    hit;
    logic                    any_select;
    logic                    timeout;
    rggen_status             hit_status;
    logic [DATA_WIDTH-1:0]   hit_read_data;

    rggen_response_mux #(
        .REGISTERS  (REGISTERS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_response_mux (
        .select        (i_register_select),
        .ready         (i_register_ready),
        .status        (i_register_status),
        .read_data     (i_register_read_data),
        .hit           (hit),
        .any_select    (any_select),
        .hit_status    (hit_status),
        .hit_read_data (hit_read_data)
    );

    // The count reaches TIMEOUT_CYCLES-1 on the last ACCESS cycle allowed; a hit in that cycle still wins.
    assign timeout = (TIMEOUT_CYCLES > 0) && any_select && !hit
                  && (count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (i_host_valid)                    next_state = ACCESS;
            ACCESS:   if (hit || !any_select || timeout)   next_state = RESPONSE;
            RESPONSE: if (i_host_response_ready)           next_state = IDLE;
            default:                                       next_state = IDLE;
        endcase
    end

    always_comb begin
        o_host_ready          = (state == IDLE);
        o_register_request    = (state == ACCESS);
        o_host_response_valid = (state == RESPONSE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_register_address      <= '0;
            o_register_direction    <= RGGEN_READ;
            o_register_write_data   <= '0;
            o_register_write_strobe <= '0;
            o_host_status           <= RGGEN_OKAY;
            o_host_read_data        <= '0;
            count                   <= '0;
        end else begin
            if (state == IDLE && i_host_valid) begin
                o_register_address      <= i_host_address;
                o_register_direction    <= i_host_write ? RGGEN_WRITE : RGGEN_READ;
                o_register_write_data   <= i_host_write_data;
                o_register_write_strobe <= i_host_write_strobe;
            end
            if (state == ACCESS) begin
                if (hit) begin
                    o_host_status    <= hit_status;
                    o_host_read_data <= (o_register_direction == RGGEN_WRITE) ? '0 : hit_read_data;
                end else if (!any_select) begin
                    o_host_status    <= ERROR_STATUS ? RGGEN_DECODE_ERROR : RGGEN_OKAY;
                    o_host_read_data <= '0;
                end else if (timeout) begin
                    o_host_status    <= RGGEN_SLAVE_ERROR;
                    o_host_read_data <= '0;
                end
            end
            count <= (state == ACCESS && next_state == ACCESS) ? count + COUNT_WIDTH'(1) : '0;
        end
    end

endmodule

// File: doc/rggen_host_bridge.md
Name: rggen_host_bridge

Overview:
Initiator end of the register access protocol. Accepts one host command at a time over a valid/ready request channel and drives a single request onto the shared register bus. It then waits for the addressed register to report select+ready, collects status and read data, and returns them on a valid/ready response channel. The block sits between a protocol-specific host adapter and the array of register instances.

Parameters:
ADDRESS_WIDTH, 16, byte address width of host and register bus
DATA_WIDTH, 32, data width; multiple of 8
REGISTERS, 1, number of register responders attached
TIMEOUT_CYCLES, 0, ACCESS cycles allowed with a register selected but not ready; 0 disables the timeout
ERROR_STATUS, 1, 1: unmapped address returns RGGEN_DECODE_ERROR; 0: returns RGGEN_OKAY

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
i_host_valid  input  1  command valid
o_host_ready  output  1  command accepted when valid&ready
i_host_address  input  ADDRESS_WIDTH  byte address
i_host_write  input  1  1=write, 0=read
i_host_write_data  input  DATA_WIDTH  write data
i_host_write_strobe  input  DATA_WIDTH/8  byte enables
o_host_response_valid  output  1  response valid
i_host_response_ready  input  1  response consumed
o_host_status  output  2  rggen_status of completed access
o_host_read_data  output  DATA_WIDTH  read data (0 for writes/errors)
o_register_request  output  1  request to all registers
o_register_address  output  ADDRESS_WIDTH  captured address
o_register_direction  output  1  rggen_direction (RGGEN_READ/RGGEN_WRITE)
o_register_write_data  output  DATA_WIDTH  captured write data
o_register_write_strobe  output  DATA_WIDTH/8  captured strobe
i_register_select  input  REGISTERS  per-register address match
i_register_ready  input  REGISTERS  per-register ready
i_register_status  input  2*REGISTERS  per-register status
i_register_read_data  input  DATA_WIDTH*REGISTERS  per-register read data

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk, rst).
- States: IDLE, ACCESS, RESPONSE. Reset state is IDLE.
- Reset values: o_host_ready=1 (state IDLE); o_host_response_valid=0; o_register_request=0; all captured address/data/strobe/status/read-data registers=0; direction=RGGEN_READ; timeout counter=0.
- o_host_ready is 1 only in IDLE. Commands presented while rst is high are ignored.
- IDLE: on valid&ready, capture address, direction, write data and strobe; go to ACCESS on the next cycle.
- ACCESS: o_register_request=1 and the captured fields are driven unchanged, so the request is stable until completion.
  - hit = OR(select&ready). On hit, capture the OR-reduction of read_data over the hit registers and the status of the lowest-index hit register, then go to RESPONSE.
  - Minimum latency is accept to response_valid = 2 cycles (IDLE→ACCESS, ACCESS→RESPONSE).
  - No select bit set in ACCESS: decode error. Status is RGGEN_DECODE_ERROR if ERROR_STATUS, else RGGEN_OKAY; read data is 0. Go to RESPONSE after one ACCESS cycle.
  - Select set but ready low: stay in ACCESS and increment the timeout counter. If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 without a hit, status is RGGEN_SLAVE_ERROR, data is 0, go to RESPONSE. The counter clears on leaving ACCESS.
  - Hit and timeout in the same cycle: the hit wins.
- Write responses always return read data 0, regardless of the read_data inputs.
- RESPONSE: o_host_response_valid=1; status and data are held stable until i_host_response_ready, then go to IDLE. A new command can be accepted the cycle after the handshake, not the same cycle.
- Multiple registers selected is a configuration error. Behaviour stays deterministic: data is OR'd, status comes from the lowest index.
- Reset asserted mid-ACCESS or mid-RESPONSE: o_register_request and o_host_response_valid drop immediately (asynchronous), the state returns to IDLE, and the transaction is lost.

Decomposition:
- rggen_rtl_pkg (existing) supplies rggen_status (RGGEN_OKAY, RGGEN_EXOKAY, RGGEN_SLAVE_ERROR, RGGEN_DECODE_ERROR) and rggen_direction.
- The state enum is local to the module.
- One sub-module, rggen_response_mux: purely combinational. Inputs: select, ready, status, read_data vectors. Outputs: hit, any_select, status, read_data, using the lowest-index status rule.

Test Plan:
- Read hit: REGISTERS=2; reg1 select=1 with ready=1 in the first ACCESS cycle, read_data=0xDEADBEEF, status=OKAY. Expect response_valid 2 cycles after accept with data 0xDEADBEEF and status OKAY; request high for exactly 1 cycle.
- Write with wait states: write 0x12345678, strobe 0b0011, reg0 ready after 3 cycles. Expect request held 4 cycles with write_data/strobe/direction stable, then response status OKAY with data 0.
- Unmapped address: no select. With ERROR_STATUS=1 expect DECODE_ERROR and data 0 two cycles after accept; with ERROR_STATUS=0 expect OKAY.
- Timeout: TIMEOUT_CYCLES=4, select=1 and ready stuck 0. Expect SLAVE_ERROR after 4 ACCESS cycles; set ready=1 on cycle 4 instead and expect OKAY (hit wins).
- Backpressure: response_ready held 0 for 5 cycles. Expect status/data stable, o_host_ready=0, and a second command accepted only after the handshake.
- Async reset mid-ACCESS: assert rst between clock edges. Expect o_register_request=0 immediately and o_host_ready=1; after release a fresh read completes normally.
